// File: rtl/i2c_target_pkg.sv
// Shared types and register-map constants for the I2C target register file.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK,
        WR_PTR,
        WR_DATA,
        RD_DATA,
        RD_MACK,
        IGNORE
    } state_t;

    localparam logic [7:0] WHO_AM_I_ADDR = 8'h75;
    localparam logic [7:0] ACCEL_XOUT_H  = 8'h3B;
    localparam logic [7:0] ACCEL_YOUT_H  = 8'h3D;
    localparam logic [7:0] PWR_MGMT_1    = 8'h6B;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one asynchronous I2C pad line: synchronizer, glitch filter and
// single-cycle rise/fall pulses aligned with the filtered level.
module i2c_line_cond #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic                  meta;
    logic [FILTER_LEN-1:0] hist;

    // hist[0] is the second synchronizer flop; the whole history must agree
    // before the accepted level moves. The idle bus level is high.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta    <= 1'b1;
            hist    <= '1;
            level_o <= 1'b1;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            meta   <= line_i;
            hist   <= (hist << 1) | FILTER_LEN'(meta);
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if ((&hist) && !level_o) begin
                level_o <= 1'b1;
                rise_o  <= 1'b1;
            end else if (!(|hist) && level_o) begin
                level_o <= 1'b0;
                fall_o  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target emulating a small sensor register map: address match, register
// pointer, burst write and burst read, plus a local preload/read port.
module i2c_target_regfile
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h68,
    parameter int         REG_COUNT  = 128,
    parameter int         FILTER_LEN = 3,
    localparam int        AW         = $clog2(REG_COUNT)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe_o,
    input  logic          loc_wr_i,
    input  logic [AW-1:0] loc_addr_i,
    input  logic [7:0]    loc_wdata_i,
    output logic [7:0]    loc_rdata_o,
    output logic          bus_wr_o,
    output logic [AW-1:0] bus_wr_addr_o,
    output logic [7:0]    bus_wr_data_o,
    output logic          busy_o
);

    localparam int WHO_IDX = int'(WHO_AM_I_ADDR) % REG_COUNT;

    logic          scl_lvl, scl_rise, scl_fall;
    logic          sda_lvl, sda_rise, sda_fall;
    logic          start_cond, stop_cond;

    state_t        state, state_n, ack_next, ack_next_n;
    logic [7:0]    shift, shift_n, rx_byte;
    logic [2:0]    cnt, cnt_n;
    logic [AW-1:0] ptr, ptr_n, ptr_inc;
    logic          oe_n, busy_n, bus_wr_n;
    logic [AW-1:0] bus_wr_addr_n;
    logic [7:0]    bus_wr_data_n;
    logic [7:0]    regs [REG_COUNT];

    i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .line_i  (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .line_i  (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    // Both lines share the same latency, so the filtered SCL level is valid
    // whenever an SDA edge pulse appears.
    assign start_cond  = sda_fall && scl_lvl;
    assign stop_cond   = sda_rise && scl_lvl;
    assign rx_byte     = {shift[6:0], sda_lvl};
    assign ptr_inc     = ptr + 1'b1;
    assign loc_rdata_o = regs[loc_addr_i];

    // Next-state and next-output logic; START/STOP override every state.
    always_comb begin
        state_n       = state;
        ack_next_n    = ack_next;
        shift_n       = shift;
        cnt_n         = cnt;
        ptr_n         = ptr;
        oe_n          = sda_oe_o;
        busy_n        = busy_o;
        bus_wr_n      = 1'b0;
        bus_wr_addr_n = bus_wr_addr_o;
        bus_wr_data_n = bus_wr_data_o;
        if (start_cond) begin
            state_n = ADDR;
            cnt_n   = 3'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b1;
        end else if (stop_cond) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_n = rx_byte;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                            state_n    = ACK;
                            ack_next_n = rx_byte[0] ? RD_DATA : WR_PTR;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                // First falling edge pulls SDA low, the second ends the ACK slot.
                ACK: if (scl_fall) begin
                    if (!sda_oe_o) begin
                        oe_n = 1'b1;
                    end else begin
                        state_n = ack_next;
                        if (ack_next == RD_DATA) begin
                            shift_n = regs[ptr];
                            oe_n    = ~regs[ptr][7];
                        end else begin
                            oe_n = 1'b0;
                        end
                    end
                end
                WR_PTR: if (scl_rise) begin
                    shift_n = rx_byte;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        ptr_n      = AW'(rx_byte);
                        state_n    = ACK;
                        ack_next_n = WR_DATA;
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shift_n = rx_byte;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bus_wr_n      = 1'b1;
                        bus_wr_addr_n = ptr;
                        bus_wr_data_n = rx_byte;
                        ptr_n         = ptr_inc;
                        state_n       = ACK;
                        ack_next_n    = WR_DATA;
                    end
                end
                // cnt counts rising edges already seen; at cnt==0 the MSB of a
                // freshly reloaded byte goes out without shifting.
                RD_DATA: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) state_n = RD_MACK;
                    end else if (scl_fall) begin
                        if (cnt == 3'd0) begin
                            oe_n = ~shift[7];
                        end else begin
                            shift_n = {shift[6:0], 1'b0};
                            oe_n    = ~shift[6];
                        end
                    end
                end
                RD_MACK: begin
                    if (scl_fall) begin
                        oe_n = 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_lvl) begin
                            ptr_n   = ptr_inc;
                            shift_n = regs[ptr_inc];
                            state_n = RD_DATA;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM, shifter, pointer and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= IDLE;
            ack_next      <= IDLE;
            shift         <= 8'h00;
            cnt           <= 3'd0;
            ptr           <= '0;
            sda_oe_o      <= 1'b0;
            busy_o        <= 1'b0;
            bus_wr_o      <= 1'b0;
            bus_wr_addr_o <= '0;
            bus_wr_data_o <= 8'h00;
        end else begin
            state         <= state_n;
            ack_next      <= ack_next_n;
            shift         <= shift_n;
            cnt           <= cnt_n;
            ptr           <= ptr_n;
            sda_oe_o      <= oe_n;
            busy_o        <= busy_n;
            bus_wr_o      <= bus_wr_n;
            bus_wr_addr_o <= bus_wr_addr_n;
            bus_wr_data_o <= bus_wr_data_n;
        end
    end

    // Register array; a bus write suppresses a same-cycle local write to the same entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= (i == WHO_IDX) ? {1'b0, SLAVE_ADDR} : 8'h00;
            end
        end else begin
            if (loc_wr_i && !(bus_wr_n && (loc_addr_i == bus_wr_addr_n))) begin
                regs[loc_addr_i] <= loc_wdata_i;
            end
            if (bus_wr_n) begin
                regs[bus_wr_addr_n] <= bus_wr_data_n;
            end
        end
    end

endmodule
